// File: rtl/gpio_pkg.sv
// Shared constants and helpers for the GPIO input conditioner.
// The optional edge-pending/interrupt logic is enabled by defining GPIO_COND_IRQ_EN.
package gpio_pkg;

   localparam int GPIO_WIDTH       = 16;
   localparam int GPIO_SYNC_STAGES = 2;
   localparam int GPIO_DB_CYCLES   = 4;

   // Ceiling log2 with a floor of 1, so a one-cycle debounce still gets a real counter bit.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      if (r < 1) r = 1;
      return r;
   endfunction

endpackage

// File: rtl/gpio_debounce_bit.sv
// One conditioned pin: synchroniser chain, debounce counter, clean level and its one-cycle delay.
// Built for every bit of gpio_input_conditioner (GPIO_COND_IRQ_EN has no effect here).
module gpio_debounce_bit
   import gpio_pkg::*;
#(
   parameter int SYNC_STAGES = GPIO_SYNC_STAGES,
   parameter int DB_CYCLES   = GPIO_DB_CYCLES
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_pin,
   input  logic i_db_en,
   output logic o_clean,
   output logic o_clean_d
);

   localparam int             CW   = clog2(DB_CYCLES);
   localparam logic [CW-1:0]  LAST = CW'(DB_CYCLES - 1);

   logic [SYNC_STAGES-1:0] r_sync;
   logic [CW-1:0]          r_cnt;
   logic                   r_clean;
   logic                   r_clean_d;

   logic                   w_sync;
   logic                   w_diff;
   logic [CW-1:0]          w_cnt_nxt;
   logic                   w_clean_nxt;

   assign w_sync = r_sync[SYNC_STAGES-1];
   assign w_diff = w_sync ^ r_clean;

   // Bypass loads the level directly; debounce needs DB_CYCLES consecutive mismatching edges.
   always_comb begin
      w_cnt_nxt   = '0;
      w_clean_nxt = r_clean;
      if (!i_db_en) begin
         w_clean_nxt = w_sync;
      end else if (w_diff) begin
         if (r_cnt == LAST) begin
            w_clean_nxt = w_sync;
         end else begin
            w_cnt_nxt = r_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync    <= '0;
         r_cnt     <= '0;
         r_clean   <= 1'b0;
         r_clean_d <= 1'b0;
      end else begin
         r_sync    <= {r_sync[SYNC_STAGES-2:0], i_pin};
         r_cnt     <= w_cnt_nxt;
         r_clean   <= w_clean_nxt;
         r_clean_d <= r_clean;
      end
   end

   assign o_clean   = r_clean;
   assign o_clean_d = r_clean_d;

endmodule

// File: rtl/gpio_input_conditioner.sv
// Pin synchronise/debounce front end of the AHB GPIO slave, with rise/fall pulses.
// Define GPIO_COND_IRQ_EN to build sticky edge_pend flags and the registered irq.
module gpio_input_conditioner
   import gpio_pkg::*;
#(
   parameter int WIDTH       = GPIO_WIDTH,
   parameter int SYNC_STAGES = GPIO_SYNC_STAGES,
   parameter int DB_CYCLES   = GPIO_DB_CYCLES
) (
   input  logic             HCLK,
   input  logic             HRESETn,
   input  logic [WIDTH-1:0] pin_in,
   input  logic [WIDTH-1:0] db_enable,
   output logic [WIDTH-1:0] clean_out,
   output logic [WIDTH-1:0] rise_pulse,
   output logic [WIDTH-1:0] fall_pulse,
   input  logic [WIDTH-1:0] irq_mask,
   input  logic [WIDTH-1:0] edge_clr,
   output logic [WIDTH-1:0] edge_pend,
   output logic             irq
);

   logic [WIDTH-1:0] w_clean;
   logic [WIDTH-1:0] w_clean_d;

   for (genvar g = 0; g < WIDTH; g++) begin : g_bit
      gpio_debounce_bit #(
         .SYNC_STAGES (SYNC_STAGES),
         .DB_CYCLES   (DB_CYCLES)
      ) u_bit (
         .i_clk     (HCLK),
         .i_rst_n   (HRESETn),
         .i_pin     (pin_in[g]),
         .i_db_en   (db_enable[g]),
         .o_clean   (w_clean[g]),
         .o_clean_d (w_clean_d[g])
      );
   end

   assign clean_out  = w_clean;
   assign rise_pulse =  w_clean & ~w_clean_d;
   assign fall_pulse = ~w_clean &  w_clean_d;

`ifdef GPIO_COND_IRQ_EN
   logic [WIDTH-1:0] r_edge_pend;
   logic             r_irq;
   logic [WIDTH-1:0] w_edge_pend_nxt;

   // A new edge in the same cycle as a clear keeps the flag set.
   assign w_edge_pend_nxt = (r_edge_pend & ~edge_clr) | rise_pulse | fall_pulse;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_edge_pend <= '0;
         r_irq       <= 1'b0;
      end else begin
         r_edge_pend <= w_edge_pend_nxt;
         r_irq       <= |(r_edge_pend & irq_mask);
      end
   end

   assign edge_pend = r_edge_pend;
   assign irq       = r_irq;
`else
   logic w_unused_irq_inputs;
   assign w_unused_irq_inputs = ^{irq_mask, edge_clr};
   assign edge_pend = '0;
   assign irq       = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Directed bench for gpio_input_conditioner with a history-based reference model.
// Expectations for edge_pend/irq follow GPIO_COND_IRQ_EN.
module tb_gpio_input_conditioner;
   import gpio_pkg::*;

   localparam int W   = 16;
   localparam int SS  = 2;
   localparam int DB  = 4;
   localparam int HN  = 4096;

   logic          HCLK = 1'b0;
   logic          HRESETn = 1'b0;
   logic [W-1:0]  pin_in = '0, db_enable = '1, irq_mask = '0, edge_clr = '0;
   logic [W-1:0]  clean_out, rise_pulse, fall_pulse, edge_pend;
   logic          irq;

   int checks = 0, errors = 0;

   gpio_input_conditioner #(.WIDTH(W), .SYNC_STAGES(SS), .DB_CYCLES(DB)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .pin_in(pin_in), .db_enable(db_enable),
      .clean_out(clean_out), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
      .irq_mask(irq_mask), .edge_clr(edge_clr), .edge_pend(edge_pend), .irq(irq)
   );

   always #5 HCLK = ~HCLK;

`ifdef GPIO_COND_IRQ_EN
   localparam bit IRQ_EN = 1'b1;
`else
   localparam bit IRQ_EN = 1'b0;
`endif

   // Reference model: per-edge history of sampled pins and db_enable since the last reset.
   logic [W-1:0] samp [HN];
   logic [W-1:0] dbh  [HN];
   int           m_n = 0;
   logic [W-1:0] m_clean = '0, m_cd = '0, m_pend = '0;
   logic         m_irq = 1'b0;

   // Level the synchroniser presents after edge k: the pin sampled SS-1 edges earlier.
   function automatic logic [W-1:0] syncw(input int k);
      int idx;
      idx = k - SS + 1;
      return (idx >= 1 && idx < HN) ? samp[idx] : '0;
   endfunction

   // clean flips at edge n only if the last DB edges all had debounce on and a pin level opposite to clean.
   function automatic logic [W-1:0] f_clean(input int n, input logic [W-1:0] cl, input logic [W-1:0] db);
      logic [W-1:0] r;
      bit ok, d;
      logic [W-1:0] s;
      r = cl;
      for (int b = 0; b < W; b++) begin
         if (!db[b]) begin
            s = syncw(n - 1);
            r[b] = s[b];
         end else begin
            ok = 1'b1;
            for (int k = n - DB + 1; k <= n; k++) begin
               if (k < 1) ok = 1'b0;
               else begin
                  d = (k == n) ? db[b] : dbh[k][b];
                  s = syncw(k - 1);
                  if (!d || s[b] == cl[b]) ok = 1'b0;
               end
            end
            if (ok) r[b] = ~cl[b];
         end
      end
      return r;
   endfunction

   always @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         m_n <= 0; m_clean <= '0; m_cd <= '0; m_pend <= '0; m_irq <= 1'b0;
      end else begin
         if (m_n + 1 < HN) begin
            samp[m_n+1] <= pin_in;
            dbh[m_n+1]  <= db_enable;
            m_n         <= m_n + 1;
         end
         m_clean <= f_clean(m_n + 1, m_clean, db_enable);
         m_cd    <= m_clean;
         if (IRQ_EN) begin
            m_pend <= (m_pend & ~edge_clr) | (m_clean ^ m_cd);
            m_irq  <= |(m_pend & irq_mask);
         end
      end
   end

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge HCLK) begin
      chk("mdl_clean", clean_out,  m_clean);
      chk("mdl_rise",  rise_pulse, m_clean & ~m_cd);
      chk("mdl_fall",  fall_pulse, ~m_clean & m_cd);
      chk("mdl_pend",  edge_pend,  m_pend);
      chk("mdl_irq",   {15'b0, irq}, {15'b0, m_irq});
   end

   task automatic tick(input int n);
      repeat (n) @(posedge HCLK);
      #2;
   endtask

   initial begin
      // 1: reset release with 5555 held
      pin_in = 16'h5555;
      tick(2);
      chk("t1_rst_clean", clean_out, 16'h0000);
      HRESETn = 1'b1;
      tick(5);
      chk("t1_e5_clean", clean_out, 16'h0000);
      tick(1);
      chk("t1_e6_clean", clean_out, 16'h5555);
      chk("t1_e6_rise", rise_pulse, 16'h5555);
      chk("t1_e6_fall", fall_pulse, 16'h0000);
      tick(1);
      chk("t1_e7_rise", rise_pulse, 16'h0000);
      pin_in = 16'h0000;
      tick(8);
      chk("t1_settle", clean_out, 16'h0000);

      // 2: 3-cycle glitch rejected, 4-cycle pulse accepted
      pin_in = 16'h0001; tick(3);
      pin_in = 16'h0000; tick(10);
      chk("t2_glitch", clean_out, 16'h0000);
      pin_in = 16'h0001; tick(4);
      pin_in = 16'h0000; tick(1);
      chk("t2_e5_clean", clean_out, 16'h0000);
      tick(1);
      chk("t2_e6_clean", clean_out, 16'h0001);
      chk("t2_e6_rise", rise_pulse, 16'h0001);
      tick(10);

      // 3: bypass on bit 3, toggling every 2 cycles
      db_enable = 16'hFFF7;
      pin_in = 16'h0008;
      tick(2);
      chk("t3_e2_clean", clean_out, 16'h0000);
      tick(1);
      chk("t3_e3_clean", clean_out, 16'h0008);
      chk("t3_e3_rise", rise_pulse, 16'h0008);
      tick(1);
      pin_in = 16'h0000; tick(2);
      pin_in = 16'h0008; tick(1);
      chk("t3_fall", fall_pulse, 16'h0008);
      for (int i = 0; i < 6; i++) begin
         tick(1);
         pin_in = pin_in ^ 16'h0008;
      end
      pin_in = 16'h0000; tick(4);
      db_enable = 16'hFFFF; tick(4);

      // db_enable dropped mid-count and reapplied restarts the count
      pin_in = 16'h0010; tick(4);
      db_enable = 16'hFFEF; tick(1);
      chk("t3_byp_mid", clean_out, 16'h0010);
      pin_in = 16'h0000; db_enable = 16'hFFFF; tick(3);
      db_enable = 16'hFFEF; tick(1);
      db_enable = 16'hFFFF; tick(10);
      chk("t3_restore", clean_out, 16'h0000);

      // 4: interrupt path on bit 2
      irq_mask = 16'h0004;
      pin_in = 16'h0004; tick(6);
      chk("t4_rise", rise_pulse, 16'h0004);
      tick(1);
      chk("t4_pend", edge_pend, IRQ_EN ? 16'h0004 : 16'h0000);
      chk("t4_irq0", {15'b0, irq}, 16'h0000);
      tick(1);
      chk("t4_irq1", {15'b0, irq}, {15'b0, IRQ_EN});
      pin_in = 16'h0000; tick(6);
      chk("t4_fall", fall_pulse, 16'h0004);
      edge_clr = 16'h0004; tick(1);
      edge_clr = 16'h0000;
      chk("t4_setwins", edge_pend, IRQ_EN ? 16'h0004 : 16'h0000);
      tick(3);
      edge_clr = 16'h0004; tick(1);
      edge_clr = 16'h0000;
      chk("t4_cleared", edge_pend, 16'h0000);
      chk("t4_irq_hold", {15'b0, irq}, {15'b0, IRQ_EN});
      tick(1);
      chk("t4_irq_off", {15'b0, irq}, 16'h0000);
      irq_mask = 16'h0000;
      tick(4);

      // 5: asynchronous reset two edges into a count
      pin_in = 16'h0080; tick(4);
      #1 HRESETn = 1'b0;
      #1;
      chk("t5_async_clean", clean_out, 16'h0000);
      chk("t5_async_pend", edge_pend, 16'h0000);
      tick(1);
      HRESETn = 1'b1;
      tick(5);
      chk("t5_e5_clean", clean_out, 16'h0000);
      tick(1);
      chk("t5_e6_clean", clean_out, 16'h0080);
      chk("t5_e6_rise", rise_pulse, 16'h0080);
      tick(4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
